// File: rtl/enigma_msg_ctrl.sv
// Message-level host controller for the Enigma core: buffers a message, feeds letters
// through the core's set/valid/done handshake and collects results for the host to drain.
module enigma_msg_ctrl #(
   parameter int unsigned MAX_LEN = 64,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_en,
   input  logic [7:0]                wr_data,
   input  logic                      start,
   input  logic                      dec_in,
   input  logic                      clear,
   output logic                      full,
   output logic                      overflow,
   output logic                      busy,
   output logic                      msg_done,
   output logic                      err,
   output logic                      core_set,
   output logic                      core_en,
   output logic                      core_valid,
   output logic [7:0]                core_din,
   output logic                      core_dec,
   input  logic [7:0]                core_dout,
   input  logic                      core_done,
   input  logic                      rd_en,
   output logic [7:0]                rd_data,
   output logic                      rd_valid,
   output logic [$clog2(MAX_LEN):0]  out_count
);

   localparam int unsigned AW = $clog2(MAX_LEN);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SEND, S_WAIT, S_DONE} state_t;

   state_t          state_q;
   logic [7:0]      ibuf_q [MAX_LEN];
   logic [7:0]      obuf_q [MAX_LEN];
   logic [CW-1:0]   in_count_q, send_idx_q, out_count_q, rd_ptr_q;
   logic [TW-1:0]   tmo_q;
   logic            overflow_q, err_q, dec_q, rd_valid_q;
   logic [7:0]      rd_data_q;

   logic [7:0]      cur_c;
   logic            is_lower, is_upper, is_letter;
   logic [7:0]      norm_c;
   logic [CW-1:0]   send_idx_d;
   logic            last_d, full_d, wr_ok, clear_ok;

   always_comb begin
      cur_c      = ibuf_q[send_idx_q[AW-1:0]];
      is_lower   = (cur_c >= 8'h61) && (cur_c <= 8'h7A);
      is_upper   = (cur_c >= 8'h41) && (cur_c <= 8'h5A);
      is_letter  = is_lower || is_upper;
      norm_c     = is_lower ? (cur_c - 8'h20) : cur_c;
      send_idx_d = send_idx_q + 1'b1;
      last_d     = (send_idx_d == in_count_q);
      full_d     = (in_count_q == CW'(MAX_LEN));
      wr_ok      = wr_en && (state_q == S_IDLE) && !full_d;
      clear_ok   = clear && ((state_q == S_IDLE) || (state_q == S_DONE));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         in_count_q  <= '0;
         send_idx_q  <= '0;
         out_count_q <= '0;
         rd_ptr_q    <= '0;
         tmo_q       <= '0;
         overflow_q  <= 1'b0;
         err_q       <= 1'b0;
         dec_q       <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         rd_valid_q <= 1'b0;
         if (clear_ok) begin
            state_q     <= S_IDLE;
            in_count_q  <= '0;
            send_idx_q  <= '0;
            out_count_q <= '0;
            rd_ptr_q    <= '0;
            tmo_q       <= '0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
         end else begin
            if (rd_en && (rd_ptr_q < out_count_q)) begin
               rd_data_q  <= obuf_q[rd_ptr_q[AW-1:0]];
               rd_valid_q <= 1'b1;
               rd_ptr_q   <= rd_ptr_q + 1'b1;
            end
            unique case (state_q)
               S_IDLE: begin
                  if (wr_en && full_d) overflow_q <= 1'b1;
                  if (wr_ok) begin
                     ibuf_q[in_count_q[AW-1:0]] <= wr_data;
                     in_count_q <= in_count_q + 1'b1;
                  end
                  // a write in the start cycle is part of the message
                  if (start) begin
                     if ((in_count_q != '0) || wr_ok) begin
                        dec_q      <= dec_in;
                        send_idx_q <= '0;
                        state_q    <= S_SETUP;
                     end else begin
                        state_q <= S_DONE;
                     end
                  end
               end
               S_SETUP: state_q <= S_SEND;
               S_SEND: begin
                  if (is_letter) begin
                     tmo_q   <= '0;
                     state_q <= S_WAIT;
                  end else begin
                     obuf_q[out_count_q[AW-1:0]] <= cur_c;
                     out_count_q <= out_count_q + 1'b1;
                     send_idx_q  <= send_idx_d;
                     state_q     <= last_d ? S_DONE : S_SEND;
                  end
               end
               S_WAIT: begin
                  if (core_done) begin
                     obuf_q[out_count_q[AW-1:0]] <= core_dout;
                     out_count_q <= out_count_q + 1'b1;
                     send_idx_q  <= send_idx_d;
                     state_q     <= last_d ? S_DONE : S_SEND;
                  end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                     obuf_q[out_count_q[AW-1:0]] <= 8'h3F;
                     out_count_q <= out_count_q + 1'b1;
                     err_q       <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     tmo_q <= tmo_q + 1'b1;
                  end
               end
               S_DONE: ;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign full       = full_d;
   assign overflow   = overflow_q;
   assign busy       = (state_q == S_SETUP) || (state_q == S_SEND) || (state_q == S_WAIT);
   assign msg_done   = (state_q == S_DONE);
   assign err        = err_q;
   assign core_set   = (state_q == S_SETUP);
   assign core_en    = busy;
   assign core_valid = (state_q == S_SEND) && is_letter;
   assign core_din   = core_valid ? norm_c : 8'h00;
   assign core_dec   = dec_q;
   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign out_count  = out_count_q;

endmodule
